// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO responder.
// Holds the frame FSM state enum, opcode values and the read-only register map.
package mdio_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ST1,
        ST_OP,
        ST_PHYAD,
        ST_REGAD,
        ST_TA,
        ST_DATA,
        ST_END,
        ST_ABORT
    } mdio_state_t;

    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;

    localparam logic [4:0] REG_STATUS = 5'd1;
    localparam logic [4:0] REG_PHYID1 = 5'd2;
    localparam logic [4:0] REG_PHYID2 = 5'd3;

    function automatic logic is_ro_reg(input logic [4:0] addr);
        return (addr == REG_STATUS) || (addr == REG_PHYID1) || (addr == REG_PHYID2);
    endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus a registered rising-edge flag.
// The rise output is high for one clock when the synchronised value goes 0 to 1.
module mdio_sync_edge (
    input  logic clk_125M,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk_125M) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign q    = sync;
    assign rise = sync & ~prev;

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO target serving a 32x16 register file; MDC/MDIO are oversampled on SYS_CLK.
// Optional MDIO_PREAMBLE_SUPPRESS_EN: accept a start after a single idle 1 instead of PREAMBLE_MIN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | counting preamble 1s, waiting for the first start bit (0)
// ST1      | expecting the second start bit (1)
// OP       | collecting the 2-bit opcode
// PHYAD    | collecting the 5-bit PHY address, deciding if addressed
// REGAD    | collecting the 5-bit register address
// TA       | turnaround; on the second bit a read starts driving 0
// DATA     | 16 data bits: shifted out (read) or shifted in (write)
// END      | read only: release the bus after bit0 was presented
// ABORT    | bad opcode; released and behaves like IDLE
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [15:0] PHY_ID1      = 16'h0000,
    parameter logic [15:0] PHY_ID2      = 16'h0000,
    parameter int unsigned PREAMBLE_MIN = 32
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST,
    input  logic        MDC,
    input  logic        MDIO_I,
    output logic        MDIO_O,
    output logic        MDIO_T,
    input  logic [4:0]  PHY_ADDR,
    input  logic [15:0] STATUS_IN,
    output logic        WR_STB,
    output logic [4:0]  WR_REG,
    output logic [15:0] WR_DATA,
    input  logic [4:0]  USR_RADDR,
    output logic [15:0] USR_RDATA
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic [5:0] PRE_THRESH = 6'd1;
`else
    localparam logic [5:0] PRE_THRESH = 6'(PREAMBLE_MIN);
`endif

    logic        mdc_s;
    logic        mdc_rise;
    logic        mdio_s;
    logic        unused_mdio_rise;

    mdio_state_t state;
    logic [5:0]  pre_cnt;
    logic [3:0]  bit_cnt;
    logic        op_rd;
    logic        addressed;
    logic [4:0]  addr_sh;
    logic [4:0]  reg_addr;
    logic [15:0] data_sh;
    logic [15:0] regs [32];

    logic [4:0]  addr_next;
    logic [15:0] wr_word;
    logic [15:0] rd_word;

    mdio_sync_edge u_sync_mdc (
        .clk_125M (SYS_CLK),
        .rst      (SYS_RST),
        .d        (MDC),
        .q        (mdc_s),
        .rise     (mdc_rise)
    );

    mdio_sync_edge u_sync_mdio (
        .clk_125M (SYS_CLK),
        .rst      (SYS_RST),
        .d        (MDIO_I),
        .q        (mdio_s),
        .rise     (unused_mdio_rise)
    );

    assign addr_next = {addr_sh[3:0], mdio_s};
    assign wr_word   = {data_sh[14:0], mdio_s};
    assign USR_RDATA = regs[USR_RADDR];

    // Registers 1..3 are live inputs/constants, never file content.
    always_comb begin
        rd_word = regs[reg_addr];
        case (reg_addr)
            REG_STATUS: rd_word = STATUS_IN;
            REG_PHYID1: rd_word = PHY_ID1;
            REG_PHYID2: rd_word = PHY_ID2;
            default:    rd_word = regs[reg_addr];
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            state     <= ST_IDLE;
            pre_cnt   <= '0;
            bit_cnt   <= '0;
            op_rd     <= 1'b0;
            addressed <= 1'b0;
            addr_sh   <= '0;
            reg_addr  <= '0;
            data_sh   <= '0;
            MDIO_T    <= 1'b1;
            MDIO_O    <= 1'b0;
            WR_STB    <= 1'b0;
            WR_REG    <= '0;
            WR_DATA   <= '0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            WR_STB <= 1'b0;
            if (mdc_rise) begin
                case (state)
                    ST_IDLE, ST_ABORT: begin
                        if (mdio_s) begin
                            if (pre_cnt != 6'd63) begin
                                pre_cnt <= pre_cnt + 6'd1;
                            end
                        end else if (pre_cnt >= PRE_THRESH) begin
                            state   <= ST_ST1;
                            pre_cnt <= '0;
                        end else begin
                            state   <= ST_IDLE;
                            pre_cnt <= '0;
                        end
                    end
                    ST_ST1: begin
                        bit_cnt <= '0;
                        state   <= mdio_s ? ST_OP : ST_IDLE;
                    end
                    ST_OP: begin
                        addr_sh <= addr_next;
                        if (bit_cnt == 4'd0) begin
                            bit_cnt <= 4'd1;
                        end else begin
                            bit_cnt <= '0;
                            case ({addr_sh[0], mdio_s})
                                OP_RD: begin
                                    op_rd <= 1'b1;
                                    state <= ST_PHYAD;
                                end
                                OP_WR: begin
                                    op_rd <= 1'b0;
                                    state <= ST_PHYAD;
                                end
                                default: begin
                                    state <= ST_ABORT;
                                end
                            endcase
                        end
                    end
                    ST_PHYAD: begin
                        addr_sh <= addr_next;
                        if (bit_cnt == 4'd4) begin
                            bit_cnt   <= '0;
                            addressed <= (addr_next == PHY_ADDR);
                            state     <= ST_REGAD;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ST_REGAD: begin
                        addr_sh <= addr_next;
                        if (bit_cnt == 4'd4) begin
                            bit_cnt  <= '0;
                            reg_addr <= addr_next;
                            state    <= ST_TA;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ST_TA: begin
                        if (bit_cnt == 4'd0) begin
                            bit_cnt <= 4'd1;
                        end else begin
                            bit_cnt <= '0;
                            state   <= ST_DATA;
                            if (op_rd && addressed) begin
                                MDIO_T  <= 1'b0;
                                MDIO_O  <= 1'b0;
                                data_sh <= rd_word;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (op_rd) begin
                            if (addressed) begin
                                MDIO_O  <= data_sh[15];
                                data_sh <= {data_sh[14:0], 1'b0};
                            end
                        end else begin
                            data_sh <= wr_word;
                        end
                        if (bit_cnt == 4'd15) begin
                            bit_cnt <= '0;
                            pre_cnt <= '0;
                            if (op_rd) begin
                                state <= addressed ? ST_END : ST_IDLE;
                            end else begin
                                state <= ST_IDLE;
                                if (addressed && !is_ro_reg(reg_addr)) begin
                                    regs[reg_addr] <= wr_word;
                                    WR_REG         <= reg_addr;
                                    WR_DATA        <= wr_word;
                                    WR_STB         <= 1'b1;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ST_END: begin
                        MDIO_T  <= 1'b1;
                        MDIO_O  <= 1'b0;
                        pre_cnt <= '0;
                        state   <= ST_IDLE;
                    end
                    default: begin
                        MDIO_T  <= 1'b1;
                        pre_cnt <= '0;
                        state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
